// File: rtl/rhd_ctrl_pkg.sv
// Shared opcodes, state encodings and default timing for the rhd_2048 session controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rhd_ctrl_pkg;

    localparam int PULSE_CYCLES_DEF   = 56;         // 500 ns at 112 MHz
    localparam int TIMEOUT_CYCLES_DEF = 1_000_000;
    localparam int FRAME_W_DEF        = 32;

    typedef enum logic [1:0] {
        OP_CONFIG = 2'd0,
        OP_RECORD = 2'd1,
        OP_ZCHECK = 2'd2,
        OP_STOP   = 2'd3
    } cmd_op_e;

    // Encoding is visible to the host on state_out.
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_CFG_PULSE = 4'd1,
        ST_CFG_WAIT  = 4'd2,
        ST_READY     = 4'd3,
        ST_REC_PULSE = 4'd4,
        ST_RECORDING = 4'd5,
        ST_REC_STOP  = 4'd6,
        ST_ZC_PULSE  = 4'd7,
        ST_ZC_WAIT   = 4'd8
    } state_e;

    // Which start port the shared strobe generator is currently driving.
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_CFG  = 2'd1,
        SEL_REC  = 2'd2,
        SEL_ZC   = 2'd3
    } strobe_sel_e;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rhd_session_ctrl_if.sv
// Host command channel into the rhd_2048 session controller.
// Latency: n/a (wiring only).
// Backpressure: cmd_ready from the controller qualifies cmd_valid.
interface rhd_session_ctrl_if #(
    parameter int FRAME_W = 32
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic               cmd_rate_20k;
    logic [FRAME_W-1:0] cmd_frames;

    modport master (
        output cmd_valid, cmd_op, cmd_rate_20k, cmd_frames,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rate_20k, cmd_frames,
        output cmd_ready
    );
endinterface

// File: rtl/rhd_strobe_gen.sv
// Fixed-width pulse stretcher: one trigger cycle becomes PULSE_CYCLES cycles of pulse.
// Latency: pulse rises the cycle after trigger; done marks the last high cycle.
// Backpressure: triggers arriving while a pulse is in flight are ignored.
module rhd_strobe_gen
    import rhd_ctrl_pkg::*;
#(
    parameter int PULSE_CYCLES = PULSE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic trigger,
    output logic pulse,
    output logic done
);

    localparam int CW = cnt_width(PULSE_CYCLES);

    logic          pulse_q, pulse_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Load the down-counter on trigger, drop the pulse once it has run out.
    always_comb begin
        pulse_d = pulse_q;
        cnt_d   = cnt_q;
        if (pulse_q) begin
            if (cnt_q == '0) begin
                pulse_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end else if (trigger) begin
            pulse_d = 1'b1;
            cnt_d   = CW'(PULSE_CYCLES - 1);
        end
    end

    // Pulse and counter registers; reset kills an in-flight pulse immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pulse = pulse_q;
    assign done  = pulse_q && (cnt_q == '0);

endmodule

// File: rtl/rhd_session_ctrl.sv
// Session sequencer between host commands and rhd_2048: enforces configure-before-use ordering.
// Latency: start strobe rises the cycle after acceptance; all status outputs are registered.
// Backpressure: cmd_ready only in IDLE/READY, plus a one-cycle STOP consume while recording.
module rhd_session_ctrl
    import rhd_ctrl_pkg::*;
#(
    parameter int PULSE_CYCLES   = PULSE_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int FRAME_W        = FRAME_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    rhd_session_ctrl_if.slave  cmd,
    input  logic               rhd_busy,
    input  logic               rhd_done,
    input  logic               frame_tick,
    output logic               config_start,
    output logic               record_start,
    output logic               zcheck_start,
    output logic               sampling_rate_20k,
    output logic [FRAME_W-1:0] frame_count,
    output logic [3:0]         state_out,
    output logic               err_timeout,
    output logic               err_illegal
);

    localparam int              TO_W    = cnt_width(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_e             state_q, state_d;
    strobe_sel_e        sel_q, sel_d;
    logic               rate_q, rate_d;
    logic               cfg_q, cfg_d;
    logic               err_to_q, err_to_d;
    logic               err_il_q, err_il_d;
    logic [FRAME_W-1:0] limit_q, limit_d;
    logic [FRAME_W-1:0] fcnt_q, fcnt_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;

    cmd_op_e            op;
    logic               cmd_rdy;
    logic               accept;
    logic               limit_hit;
    logic               trigger;
    logic               str_pulse;
    logic               str_done;

    // One stretcher serves all three start ports; sel_q steers it.
    rhd_strobe_gen #(
        .PULSE_CYCLES (PULSE_CYCLES)
    ) u_strobe (
        .clk     (clk),
        .rst     (rst),
        .trigger (trigger),
        .pulse   (str_pulse),
        .done    (str_done)
    );

    // Next-state, handshake and bookkeeping for the session sequence.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        rate_d    = rate_q;
        cfg_d     = cfg_q;
        err_to_d  = err_to_q;
        err_il_d  = err_il_q;
        limit_d   = limit_q;
        fcnt_d    = fcnt_q;
        to_cnt_d  = to_cnt_q;
        trigger   = 1'b0;
        op        = cmd_op_e'(cmd.cmd_op);
        cmd_rdy   = (state_q == ST_IDLE) || (state_q == ST_READY);
        accept    = cmd.cmd_valid && cmd_rdy;
        // Widened so a saturated counter can never alias onto the limit.
        limit_hit = (limit_q != '0) && (({1'b0, fcnt_q} + 1'b1) == {1'b0, limit_q});

        case (state_q)
            ST_IDLE, ST_READY: begin
                if (accept) begin
                    case (op)
                        OP_CONFIG: begin
                            rate_d   = cmd.cmd_rate_20k;
                            err_to_d = 1'b0;
                            err_il_d = 1'b0;
                            cfg_d    = 1'b0;
                            sel_d    = SEL_CFG;
                            trigger  = 1'b1;
                            state_d  = ST_CFG_PULSE;
                        end
                        OP_RECORD: begin
                            if ((state_q == ST_READY) && cfg_q) begin
                                limit_d = cmd.cmd_frames;
                                fcnt_d  = '0;
                                sel_d   = SEL_REC;
                                trigger = 1'b1;
                                state_d = ST_REC_PULSE;
                            end else begin
                                err_il_d = 1'b1;
                            end
                        end
                        OP_ZCHECK: begin
                            if ((state_q == ST_READY) && cfg_q) begin
                                sel_d   = SEL_ZC;
                                trigger = 1'b1;
                                state_d = ST_ZC_PULSE;
                            end else begin
                                err_il_d = 1'b1;
                            end
                        end
                        default: begin
                            // STOP with nothing running is harmless.
                        end
                    endcase
                end
            end
            ST_CFG_PULSE, ST_ZC_PULSE: begin
                if (str_done) begin
                    to_cnt_d = '0;
                    state_d  = (state_q == ST_CFG_PULSE) ? ST_CFG_WAIT : ST_ZC_WAIT;
                end
            end
            ST_CFG_WAIT, ST_ZC_WAIT: begin
                // A done arriving on the final allowed cycle still wins.
                if (rhd_done) begin
                    if (state_q == ST_CFG_WAIT) begin
                        cfg_d = 1'b1;
                    end
                    state_d = ST_READY;
                end else if (to_cnt_q == TO_LAST) begin
                    err_to_d = 1'b1;
                    cfg_d    = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            ST_REC_PULSE: begin
                if (str_done) begin
                    state_d = ST_RECORDING;
                end
            end
            ST_RECORDING: begin
                if (frame_tick && !(&fcnt_q)) begin
                    fcnt_d = fcnt_q + 1'b1;
                end
                if (rhd_done) begin
                    state_d = ST_READY;
                end else if (frame_tick && limit_hit) begin
                    state_d = ST_REC_STOP;
                end else if (cmd.cmd_valid && (op == OP_STOP)) begin
                    // Side-door consume: the host cannot otherwise hand over STOP here.
                    cmd_rdy = 1'b1;
                    state_d = ST_REC_STOP;
                end
            end
            ST_REC_STOP: begin
                if (!rhd_busy) begin
                    state_d = ST_READY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Session state and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sel_q    <= SEL_NONE;
            rate_q   <= 1'b0;
            cfg_q    <= 1'b0;
            err_to_q <= 1'b0;
            err_il_q <= 1'b0;
            limit_q  <= '0;
            fcnt_q   <= '0;
            to_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rate_q   <= rate_d;
            cfg_q    <= cfg_d;
            err_to_q <= err_to_d;
            err_il_q <= err_il_d;
            limit_q  <= limit_d;
            fcnt_q   <= fcnt_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    // Ready is held low during reset so every output reads zero there.
    assign cmd.cmd_ready     = cmd_rdy & ~rst;
    assign config_start      = str_pulse && (sel_q == SEL_CFG);
    assign record_start      = str_pulse && (sel_q == SEL_REC);
    assign zcheck_start      = str_pulse && (sel_q == SEL_ZC);
    assign sampling_rate_20k = rate_q;
    assign frame_count       = fcnt_q;
    assign state_out         = state_q;
    assign err_timeout       = err_to_q;
    assign err_illegal       = err_il_q;

endmodule

// File: doc/rhd_session_ctrl.md
Name: rhd_session_ctrl

Overview:
- Session sequencer that sits between the host/command interface and rhd_2048.
- Accepts host commands over a valid/ready handshake and enforces the legal order: configure first, then record or impedance-check.
- Drives the stretched config/record/zcheck start strobes into rhd_2048 and latches the sampling-rate select.
- Supervises each operation with a busy/done handshake, counts recorded frames and reports timeouts and illegal commands as sticky errors.

Parameters:
PULSE_CYCLES, 56, width of each start strobe in clk cycles (500 ns at 112 MHz)
TIMEOUT_CYCLES, 1_000_000, max cycles from strobe end to rhd_done for config/zcheck
FRAME_W, 32, width of frame counter and frame-limit input

Ports:
clk  in  1  system clock (112 MHz)
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  host command valid
cmd_ready  out  1  high only in IDLE or READY
cmd_op  in  2  0=CONFIG 1=RECORD 2=ZCHECK 3=STOP
cmd_rate_20k  in  1  sampling-rate select; sampled with CONFIG
cmd_frames  in  FRAME_W  frame limit; sampled with RECORD (0 = unbounded)
rhd_busy  in  1  rhd_2048 operation in progress
rhd_done  in  1  1-cycle pulse at end of config/zcheck/record
frame_tick  in  1  1-cycle pulse per completed channel sweep
config_start  out  1  strobe to rhd_2048
record_start  out  1  strobe to rhd_2048
zcheck_start  out  1  strobe to rhd_2048
sampling_rate_20k  out  1  latched rate select to rhd_2048
frame_count  out  FRAME_W  frames recorded in current session
state_out  out  4  current state encoding
err_timeout  out  1  sticky; cleared by accepted CONFIG
err_illegal  out  1  sticky; cleared by accepted CONFIG

Behaviour:
- Reset is asynchronous and active-high. Reset values: all outputs 0, state IDLE, configured flag 0.
- A command is accepted on a cycle where cmd_valid && cmd_ready.
- States: IDLE, CFG_PULSE, CFG_WAIT, READY, REC_PULSE, RECORDING, REC_STOP, ZC_PULSE, ZC_WAIT.
- IDLE:
  - CONFIG: latch cmd_rate_20k into sampling_rate_20k, clear errors -> CFG_PULSE.
  - RECORD or ZCHECK: set err_illegal, stay IDLE.
  - STOP: no-op.
- Pulse states: the strobe is high for exactly PULSE_CYCLES cycles, starting the cycle after acceptance. A down-counter reloads to PULSE_CYCLES-1 on entry; the state exits when the counter reaches 0.
- CFG_WAIT / ZC_WAIT:
  - Wait for rhd_done -> READY (configured flag set after config).
  - Timeout counter starts at 0 on entry. When it reaches TIMEOUT_CYCLES: set err_timeout, clear the configured flag, go to IDLE.
  - rhd_done on the same cycle the limit is hit counts as success.
- READY:
  - CONFIG: reconfigure, same as from IDLE.
  - RECORD: latch cmd_frames, clear frame_count -> REC_PULSE -> RECORDING.
  - ZCHECK: -> ZC_PULSE -> ZC_WAIT.
  - STOP: no-op.
- RECORDING:
  - Each frame_tick increments frame_count. frame_count saturates at all-ones and never wraps.
  - When a nonzero limit is reached (frame_count+1 == limit on a tick) -> REC_STOP.
  - rhd_done -> READY.
  - Host STOP cannot be accepted while cmd_ready=0. A separate stop path is therefore sampled directly: cmd_valid with cmd_op==3 in RECORDING -> REC_STOP, with cmd_ready pulsed for that one cycle to consume it.
- REC_STOP: record_start is low. Wait for rhd_busy==0 -> READY. No timeout applies.
- cmd_ready is 0 in all pulse/wait/recording states, except the STOP consume cycle.
- Simultaneous frame_tick and rhd_done in RECORDING: count the tick, then go to READY.
- At most one strobe is ever high. Strobes are registered outputs with no combinational path from cmd_*.
- rst asserted mid-pulse drops the strobe immediately (asynchronous). Re-configuration is then required before record/zcheck.

Decomposition:
- Package rhd_ctrl_pkg holds:
  - cmd opcode constants (OP_CONFIG/RECORD/ZCHECK/STOP);
  - state encodings (4-bit, exposed on state_out);
  - the default PULSE_CYCLES/TIMEOUT_CYCLES.
- One sub-module, rhd_strobe_gen: a parameterised fixed-width pulse stretcher (trigger in, pulse out, done out). Instantiate it once and steer its output to the selected start port by a registered select.

Test Plan:
- Reset, then CONFIG with rate_20k=1:
  - sampling_rate_20k=1 from the cycle after acceptance;
  - config_start high exactly 56 cycles;
  - rhd_done 100 cycles later -> state READY, cmd_ready=1.
- RECORD in IDLE (no config): err_illegal=1, no strobe, state IDLE. A following CONFIG clears err_illegal.
- Bounded record:
  - After config, RECORD with cmd_frames=5.
  - 5 frame_ticks -> frame_count=5, REC_STOP.
  - Hold rhd_busy 20 cycles -> READY after busy falls.
- Host stop while recording:
  - RECORD with cmd_frames=0, 3 ticks, then STOP.
  - cmd_ready pulses 1 cycle; frame_count stays 3; REC_STOP -> READY.
- Timeout:
  - TIMEOUT_CYCLES=1000, ZCHECK with no rhd_done.
  - err_timeout=1 at cycle 1000 after the strobe ends; state IDLE.
  - Subsequent RECORD flags err_illegal.
- Reset mid-pulse:
  - Assert rst at cycle 20 of config_start.
  - config_start falls within the same cycle; all outputs 0; state IDLE.
